// File: rtl/power_seq.sv
// power_seq: sequential shift-add computation of number^2 and number^3
module power_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   number,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] square,
  output logic [3*W-1:0] cube
);
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ   = 2'd1;
  localparam logic [1:0] CU   = 2'd2;
  logic [1:0]     state_q, state_d;
  logic [W-1:0]   op_q, op_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [3*W-1:0] mc_q, mc_d;
  logic [3*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] sq_q, sq_d;
  logic [3*W-1:0] cu_q, cu_d;
  logic           done_q, done_d;
  logic [3*W-1:0] sum;
  logic           last;
  // one shift-add step: multiplier bits tested LSB first, multiplicand shifted left
  assign sum  = acc_q + (sh_q[0] ? mc_q : '0);
  assign last = cnt_q == CW'(W - 1);
  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    cu_d    = cu_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SQ;
        op_d    = number;
        sh_d    = number;
        mc_d    = {{(2*W){1'b0}}, number};
        acc_d   = '0;
        cnt_d   = '0;
      end
      SQ: begin
        acc_d = sum;
        sh_d  = sh_q >> 1;
        mc_d  = mc_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = CU;
          prod_d  = sum[2*W-1:0];
          acc_d   = '0;
          sh_d    = op_q;
          mc_d    = {{W{1'b0}}, sum[2*W-1:0]};
          cnt_d   = '0;
        end
      end
      CU: begin
        acc_d = sum;
        sh_d  = sh_q >> 1;
        mc_d  = mc_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          sq_d    = prod_q;
          cu_d    = sum;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers, all cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      sq_q    <= '0;
      cu_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      cu_q    <= cu_d;
      done_q  <= done_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign square = sq_q;
  assign cube   = cu_q;
endmodule

// File: tb/tb_power_seq.sv
// tb_power_seq: directed checks of power_seq latency, results, start handling and reset
module tb_power_seq;
  localparam int W = 16;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   number = '0;
  logic           busy, done;
  logic [2*W-1:0] square;
  logic [3*W-1:0] cube;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  power_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .number(number),
    .busy(busy), .done(done), .square(square), .cube(cube)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // called at the negedge right after the accepting edge; returns at the done negedge
  task automatic wait_done(output int lat, output int bz, output int held);
    logic [2*W-1:0] s0;
    logic [3*W-1:0] c0;
    s0 = square;
    c0 = cube;
    lat = 0;
    bz = 0;
    held = 1;
    while (!done && lat < 40) begin
      if (lat > 0 && busy) bz++;
      if (square !== s0 || cube !== c0) held = 0;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run(input logic [W-1:0] n, input logic [63:0] es, input logic [63:0] ec);
    int lat, bz, held;
    @(negedge clk);
    start = 1'b1;
    number = n;
    @(negedge clk);
    start = 1'b0;
    number = ~n;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_done(lat, bz, held);
    chk("latency", 64'(lat), 64'd32);
    chk("busy_cycles", 64'(bz), 64'd31);
    chk("no_intermediate", 64'(held), 64'd1);
    chk("busy_low_at_done", 64'(busy), 64'd0);
    chk("square", 64'(square), es);
    chk("cube", 64'(cube), ec);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask
  initial begin
    int lat, bz, held, nd;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_square", 64'(square), 64'd0);
    chk("rst_cube", 64'(cube), 64'd0);
    rst = 1'b0;
    run(16'd3, 64'd9, 64'd27);
    run(16'd0, 64'd0, 64'd0);
    run(16'd65535, 64'd4294836225, 64'd281462092005375);
    // second start during SQ must be ignored
    @(negedge clk);
    start = 1'b1;
    number = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    number = 16'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bz, held);
    chk("ignore_latency", 64'(lat), 64'd22);
    chk("ignore_square", 64'(square), 64'd25);
    chk("ignore_cube", 64'(cube), 64'd125);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ignore_no_second_done", 64'(nd), 64'd0);
    // start held high: back-to-back launches every 33 cycles
    @(negedge clk);
    start = 1'b1;
    number = 16'd2;
    @(negedge clk);
    wait_done(lat, bz, held);
    chk("held_first_latency", 64'(lat), 64'd32);
    chk("held_square_2", 64'(square), 64'd4);
    chk("held_cube_2", 64'(cube), 64'd8);
    number = 16'd10;
    @(negedge clk);
    wait_done(lat, bz, held);
    chk("held_done_interval", 64'(lat + 1), 64'd33);
    chk("held_square_10", 64'(square), 64'd100);
    chk("held_cube_10", 64'(cube), 64'd1000);
    start = 1'b0;
    @(negedge clk);
    chk("held_done_one_cycle", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    // reset mid-computation aborts without done
    @(negedge clk);
    start = 1'b1;
    number = 16'd9;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_square", 64'(square), 64'd0);
    chk("abort_cube", 64'(cube), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run(16'd4, 64'd16, 64'd64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
